// File: rtl/queue_display_ctrl_pkg.sv
// rtl/queue_display_ctrl_pkg.sv - shared types, constants and blanking helper for the queue display
package queue_display_ctrl_pkg;

  localparam int VAL_W   = 10;
  localparam int VAL_MAX = 999;
  localparam int CNT_W   = $clog2(VAL_W);

  localparam logic [3:0]  BLANK_DIGIT = 4'hF;
  // Display shows "  0": hundreds and tens unlit, units zero
  localparam logic [11:0] BCD_RESET   = {BLANK_DIGIT, BLANK_DIGIT, 4'h0};

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  typedef enum logic {REQ_TKT, REQ_SRV} req_t;

  // Leading-zero blanking: tens only blank when hundreds is also zero
  function automatic logic [11:0] blank_bcd(input logic [11:0] d);
    logic [3:0] h;
    logic [3:0] t;
    h = d[11:8];
    t = d[7:4];
    if (d[11:8] == 4'd0) h = BLANK_DIGIT;
    if (d[11:8] == 4'd0 && d[7:4] == 4'd0) t = BLANK_DIGIT;
    return {h, t, d[3:0]};
  endfunction

endpackage

// File: rtl/queue_display_ctrl_if.sv
// rtl/queue_display_ctrl_if.sv - requester handshakes and display outputs of the queue display
interface queue_display_if;
  import queue_display_ctrl_pkg::*;

  logic [VAL_W-1:0] tkt_val;
  logic             tkt_valid;
  logic             tkt_ready;
  logic [VAL_W-1:0] srv_val;
  logic             srv_valid;
  logic             srv_ready;
  logic [11:0]      tkt_bcd;
  logic [11:0]      srv_bcd;
  logic             srv_new;
  logic             busy;

  modport master (
    output tkt_val, tkt_valid, srv_val, srv_valid,
    input  tkt_ready, srv_ready, tkt_bcd, srv_bcd, srv_new, busy
  );

  modport slave (
    input  tkt_val, tkt_valid, srv_val, srv_valid,
    output tkt_ready, srv_ready, tkt_bcd, srv_bcd, srv_new, busy
  );

endinterface

// File: rtl/queue_display_ctrl_bcd_dabble.sv
// rtl/queue_display_ctrl_bcd_dabble.sv - iterative double-dabble binary to three-digit BCD
module bcd_dabble
  import queue_display_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             done,
  output logic [11:0]      bcd
);

  logic [VAL_W-1:0]  bin_sr;
  logic [11:0]       bcd_sr;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic [11:0]       adj;
  logic [11+VAL_W:0] sh;

  // done marks the cycle whose rising edge performs the final iteration
  assign done = run && (cnt == CNT_W'(VAL_W - 1));
  assign bcd  = bcd_sr;

  // One iteration: add 3 to every nibble >= 5, then shift {bcd, bin} left
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin_sr} << 1;
  end

  // Load on start, then iterate once per cycle until VAL_W iterations are done
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      bin_sr <= bin;
      bcd_sr <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      bin_sr <= sh[VAL_W-1:0];
      bcd_sr <= sh[11+VAL_W:VAL_W];
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/queue_display_ctrl.sv
// rtl/queue_display_ctrl.sv - round-robin update arbiter and digit registers for the queue display
module queue_display_ctrl
  import queue_display_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  queue_display_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  req_t             last;
  logic             tkt_acc;
  logic             srv_acc;
  logic             start;
  logic             done;
  logic [VAL_W-1:0] sel_val;
  logic [VAL_W-1:0] clamp_val;
  logic [11:0]      dab_bcd;

  // Loser of a tie is whoever was granted last; only offered in IDLE
  assign bus.tkt_ready = (state == IDLE) && (!bus.srv_valid || last == REQ_SRV);
  assign bus.srv_ready = (state == IDLE) && (!bus.tkt_valid || last == REQ_TKT);
  assign tkt_acc       = bus.tkt_valid && bus.tkt_ready;
  assign srv_acc       = bus.srv_valid && bus.srv_ready;
  assign start         = tkt_acc || srv_acc;
  assign sel_val       = tkt_acc ? bus.tkt_val : bus.srv_val;
  assign clamp_val     = (sel_val > VAL_W'(VAL_MAX)) ? VAL_W'(VAL_MAX) : sel_val;
  assign bus.busy      = (state != IDLE);

  bcd_dabble u_dabble (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (clamp_val),
    .done  (done),
    .bcd   (dab_bcd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept -> shift for VAL_W cycles -> one commit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (done)  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last doubles as the grant ID of the conversion in flight
  always_ff @(posedge clk) begin
    if (rst)          last <= REQ_SRV;
    else if (tkt_acc) last <= REQ_TKT;
    else if (srv_acc) last <= REQ_SRV;
  end

  // Commit blanked digits to the granted requester's register only
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tkt_bcd <= BCD_RESET;
      bus.srv_bcd <= BCD_RESET;
      bus.srv_new <= 1'b0;
    end else begin
      bus.srv_new <= 1'b0;
      if (state == COMMIT) begin
        if (last == REQ_TKT) begin
          bus.tkt_bcd <= blank_bcd(dab_bcd);
        end else begin
          bus.srv_bcd <= blank_bcd(dab_bcd);
          bus.srv_new <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_queue_display_ctrl.sv
// tb/tb_queue_display_ctrl.sv - directed self-checking bench for queue_display_ctrl
module tb_queue_display_ctrl;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  queue_display_if bus();

  queue_display_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise a request, wait (bounded) for ready, accept on the next edge, drop valid
  task automatic send(input bit is_srv, input logic [9:0] v);
    int n;
    n = 0;
    if (is_srv) begin bus.srv_val = v; bus.srv_valid = 1'b1; end
    else        begin bus.tkt_val = v; bus.tkt_valid = 1'b1; end
    #1;
    while (!(is_srv ? bus.srv_ready : bus.tkt_ready) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk(is_srv ? "srv_accept" : "tkt_accept", is_srv ? bus.srv_ready : bus.tkt_ready, 1);
    @(posedge clk); #1;
    if (is_srv) bus.srv_valid = 1'b0;
    else        bus.tkt_valid = 1'b0;
  endtask

  // Edges T1..T11 after the accept, then sample mid-cycle
  task automatic wait_commit();
    repeat (11) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.tkt_valid = 1'b0;
    bus.srv_valid = 1'b0;
    bus.tkt_val   = '0;
    bus.srv_val   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tkt_bcd", bus.tkt_bcd, 12'hFF0);
    chk("rst_srv_bcd", bus.srv_bcd, 12'hFF0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_srv_new", bus.srv_new, 0);

    // Lone ticket request is granted in the same cycle
    bus.tkt_val = 10'd7;
    bus.tkt_valid = 1'b1;
    #1;
    chk("t7_tkt_ready", bus.tkt_ready, 1);
    chk("t7_srv_ready", bus.srv_ready, 0);
    @(posedge clk); #1;
    bus.tkt_valid = 1'b0;
    chk("t7_busy", bus.busy, 1);
    chk("t7_ready_busy", bus.tkt_ready, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t7_before_t11", bus.tkt_bcd, 12'hFF0);
    chk("t7_busy_t10", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t7_tkt_bcd", bus.tkt_bcd, 12'hFF7);
    chk("t7_srv_bcd", bus.srv_bcd, 12'hFF0);
    chk("t7_srv_new", bus.srv_new, 0);
    chk("t7_busy_done", bus.busy, 0);

    // Now-serving values with different blanking
    send(1'b1, 10'd405);
    wait_commit();
    chk("s405_srv_bcd", bus.srv_bcd, 12'h405);
    chk("s405_srv_new", bus.srv_new, 1);
    chk("s405_tkt_bcd", bus.tkt_bcd, 12'hFF7);
    @(negedge clk);
    chk("s405_srv_new_pulse", bus.srv_new, 0);
    send(1'b1, 10'd60);
    wait_commit();
    chk("s60_srv_bcd", bus.srv_bcd, 12'hF60);
    send(1'b1, 10'd0);
    wait_commit();
    chk("s0_srv_bcd", bus.srv_bcd, 12'hFF0);

    // Clamp above VAL_MAX
    send(1'b0, 10'd1023);
    wait_commit();
    chk("t1023_tkt_bcd", bus.tkt_bcd, 12'h999);
    chk("t1023_srv_new", bus.srv_new, 0);
    chk("t1023_srv_bcd", bus.srv_bcd, 12'hFF0);

    // Continuous contention from reset: tkt first, then alternate every 12 cycles
    @(negedge clk);
    rst = 1'b1;
    bus.tkt_val = 10'd12;
    bus.srv_val = 10'd34;
    bus.tkt_valid = 1'b1;
    bus.srv_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 48; i++) begin
      #1;
      chk("rr_tkt_ready", bus.tkt_ready, 32'((i % 24) == 0));
      chk("rr_srv_ready", bus.srv_ready, 32'((i % 24) == 12));
      if (i < 48) @(negedge clk);
    end
    bus.tkt_valid = 1'b0;
    bus.srv_valid = 1'b0;
    chk("rr_tkt_bcd", bus.tkt_bcd, 12'hF12);
    chk("rr_srv_bcd", bus.srv_bcd, 12'hF34);

    // Reset at T5 of a conversion; held request re-arbitrates afterwards
    @(negedge clk);
    bus.srv_val = 10'd888;
    bus.srv_valid = 1'b1;
    #1;
    chk("s888_ready", bus.srv_ready, 1);
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s888_busy_t4", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("s888_rst_srv_bcd", bus.srv_bcd, 12'hFF0);
    chk("s888_rst_tkt_bcd", bus.tkt_bcd, 12'hFF0);
    chk("s888_rst_busy", bus.busy, 0);
    chk("s888_rst_srv_new", bus.srv_new, 0);
    rst = 1'b0;
    #1;
    chk("s888_rearb_ready", bus.srv_ready, 1);
    @(posedge clk); #1;
    bus.srv_valid = 1'b0;
    wait_commit();
    chk("s888_srv_bcd", bus.srv_bcd, 12'h888);
    chk("s888_srv_new", bus.srv_new, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
